// File: rtl/cpu_pkg.sv
// Shared CPU datapath widths and register-file address/data types.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_cell.sv
// Single register of the file: asynchronous active-high clear plus load enable.
module reg_file_cell
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk or posedge clr_i) begin
        if (clr_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/reg_file.sv
// 8x16 register file: one synchronous write port, two combinational read ports.
// rst_n is active-high despite its name; writes are blocked while it is asserted.
module reg_file
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] in,
    input  logic              enable,
    input  logic [ADDR_W-1:0] sel_A,
    input  logic [ADDR_W-1:0] sel_B,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] out_A,
    output logic [DATA_W-1:0] out_B
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0] we;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    always_comb begin
        we = '0;
        if (enable) begin
            we[in] = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        reg_file_cell #(
            .DATA_W (DATA_W)
        ) u_cell (
            .clk    (clk),
            .clr_i  (rst_n),
            .load_i (we[g]),
            .d_i    (d),
            .q_o    (regs[g])
        );
    end

    // No write-through bypass: reads always reflect the stored value.
    always_comb begin
        out_A = regs[sel_A];
        out_B = regs[sel_B];
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic [2:0]  in;
    logic        enable;
    logic [2:0]  sel_A;
    logic [2:0]  sel_B;
    logic [15:0] d;
    logic [15:0] out_A;
    logic [15:0] out_B;

    int unsigned n_cmp;
    int unsigned n_err;

    reg_file #(
        .DATA_W (16),
        .ADDR_W (3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in),
        .enable (enable),
        .sel_A  (sel_A),
        .sel_B  (sel_B),
        .d      (d),
        .out_A  (out_A),
        .out_B  (out_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [15:0] v);
        @(negedge clk);
        in     = a;
        d      = v;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b1;
        enable = 1'b1;
        in     = 3'd3;
        d      = 16'hFFFF;
        sel_A  = '0;
        sel_B  = '0;

        // Reset with a write attempt pending on r3
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            sel_A = 3'(i);
            sel_B = 3'(7 - i);
            #1;
            chk($sformatf("rst_A%0d", i), out_A, 16'h0000);
            chk($sformatf("rst_B%0d", 7 - i), out_B, 16'h0000);
        end

        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b0;
        sel_A  = 3'd3;
        #1;
        chk("r3_after_rst", out_A, 16'h0000);

        // Basic write/read
        write_reg(3'd1, 16'hABCD);
        sel_A = 3'd1;
        sel_B = 3'd2;
        #1;
        chk("wr1_A", out_A, 16'hABCD);
        chk("wr1_B", out_B, 16'h0000);

        // Write disabled
        @(negedge clk);
        in     = 3'd1;
        d      = 16'h4444;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("disabled_r1", out_A, 16'hABCD);

        // Multiple registers, both ports
        write_reg(3'd2, 16'h4444);
        write_reg(3'd7, 16'h3333);
        sel_A = 3'd2;
        sel_B = 3'd7;
        #1;
        chk("r2_A", out_A, 16'h4444);
        chk("r7_B", out_B, 16'h3333);
        sel_A = 3'd7;
        #1;
        chk("same_A", out_A, 16'h3333);
        chk("same_B", out_B, 16'h3333);
        write_reg(3'd0, 16'h1234);
        sel_A = 3'd0;
        sel_B = 3'd1;
        #1;
        chk("r0_A", out_A, 16'h1234);
        chk("r1_hold_B", out_B, 16'hABCD);

        // Write-to-read latency on the same register
        @(negedge clk);
        sel_A  = 3'd5;
        in     = 3'd5;
        d      = 16'hBEEF;
        enable = 1'b1;
        #1;
        chk("r5_pre_edge", out_A, 16'h0000);
        @(posedge clk);
        #1;
        chk("r5_post_edge", out_A, 16'hBEEF);
        @(negedge clk);
        enable = 1'b0;

        // Asynchronous reset between edges
        sel_A = 3'd1;
        sel_B = 3'd2;
        #1;
        chk("pre_async_A", out_A, 16'hABCD);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("async_A1", out_A, 16'h0000);
        chk("async_B2", out_B, 16'h0000);
        sel_A = 3'd5;
        sel_B = 3'd7;
        #1;
        chk("async_A5", out_A, 16'h0000);
        chk("async_B7", out_B, 16'h0000);

        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            sel_A = 3'(i);
            sel_B = 3'(i);
            #1;
            chk($sformatf("post_rst_A%0d", i), out_A, 16'h0000);
            chk($sformatf("post_rst_B%0d", i), out_B, 16'h0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
